// File: rtl/fullsend_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t : sequencing FSM states
//   FUNCT3_*    : RV32 load/store size encodings
//   LSU_ERR_*   : response error codes
//   lsu_fault() : classifies a request as ok / illegal / misaligned / out of range
package fullsend_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } lsu_state_t;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam logic [1:0] LSU_ERR_OK       = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_RANGE    = 2'b10;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;

  // Priority: illegal encoding first, then alignment, then range.
  // Stores have no unsigned variants, so any store with funct3[2] set is illegal.
  function automatic logic [1:0] lsu_fault(
    input logic        we,
    input logic [2:0]  funct3,
    input logic [31:0] addr,
    input int unsigned mem_words
  );
    logic illegal;
    logic misaligned;
    logic out_of_range;
    illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (we && funct3[2]);
    misaligned   = (((funct3 == FUNCT3_H) || (funct3 == FUNCT3_HU)) && addr[0]) ||
                   ((funct3 == FUNCT3_W) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= mem_words);
    if (illegal)           return LSU_ERR_ILLEGAL;
    else if (misaligned)   return LSU_ERR_MISALIGN;
    else if (out_of_range) return LSU_ERR_RANGE;
    else                   return LSU_ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   i_ext_word : word read from memory, source for load extraction
//   i_mrg_word : old memory word for sub-word store merging
//   i_wdata    : store data (low byte/half used for B/H)
//   i_lane     : byte address within the word
//   i_funct3   : access size / signedness
//   o_rdata    : sign/zero extended load data
//   o_merged   : i_mrg_word with the addressed byte/half/word replaced
module lsu_align
  import fullsend_pkg::*;
(
  input  logic [31:0] i_ext_word,
  input  logic [31:0] i_mrg_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wrep;
  logic [3:0]  w_byte_en;

  always_comb begin
    w_byte  = i_ext_word[8*i_lane +: 8];
    // Halfwords are aligned, so only lane 0 or lane 2 can be addressed.
    w_half  = i_lane[1] ? i_ext_word[31:16] : i_ext_word[15:0];
    o_rdata = '0;
    case (i_funct3)
      FUNCT3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
      FUNCT3_H:  o_rdata = {{16{w_half[15]}}, w_half};
      FUNCT3_W:  o_rdata = i_ext_word;
      FUNCT3_BU: o_rdata = {24'b0, w_byte};
      FUNCT3_HU: o_rdata = {16'b0, w_half};
      default:   o_rdata = '0;
    endcase
  end

  // Replicate the store data across all lanes so that each byte lane can
  // simply pick its own slice; the enable mask decides which lanes change.
  always_comb begin
    w_wrep    = '0;
    w_byte_en = 4'b0000;
    case (i_funct3)
      FUNCT3_B: begin
        w_wrep    = {4{i_wdata[7:0]}};
        w_byte_en = 4'b0001 << i_lane;
      end
      FUNCT3_H: begin
        w_wrep    = {2{i_wdata[15:0]}};
        w_byte_en = i_lane[1] ? 4'b1100 : 4'b0011;
      end
      FUNCT3_W: begin
        w_wrep    = i_wdata;
        w_byte_en = 4'b1111;
      end
      default: begin
        w_wrep    = '0;
        w_byte_en = 4'b0000;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_merged[8*gi +: 8] = w_byte_en[gi] ? w_wrep[8*gi +: 8] : i_mrg_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32 load/store per handshake from the core,
// sequences the memory accesses (read-modify-write for sub-word stores),
// and returns exactly one response per request.
//   clk, reset                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only when idle)
//   req_we/funct3/addr/wdata   : request fields
//   resp_valid/resp_ready      : response handshake, response held until taken
//   resp_rdata/resp_err        : extended load data / error code
//   mem_address/in/en/r_w/out  : word-addressed memory port
module load_store_unit
  import fullsend_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 10240,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_in,
  output logic        mem_en,
  output logic        mem_r_w,
  input  logic [31:0] mem_out
);

  localparam int unsigned CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_RD_LAT - 1);

  lsu_state_t       r_state;
  lsu_state_t       w_state_next;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_word;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [1:0]  w_fault;
  logic        w_accept;
  logic        w_wait_done;
  logic [31:0] w_ext;
  logic [31:0] w_merged;

  assign w_fault     = lsu_fault(req_we, req_funct3, req_addr, MEM_WORDS);
  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_wait_done = (r_wait_cnt == '0);

  assign mem_address = {2'b00, r_addr[31:2]};
  assign resp_rdata  = (r_state == S_RESP) ? r_rdata : 32'h0;
  assign resp_err    = (r_state == S_RESP) ? r_err : LSU_ERR_OK;

  lsu_align u_align (
    .i_ext_word (mem_out),
    .i_mrg_word (r_word),
    .i_wdata    (r_wdata),
    .i_lane     (r_addr[1:0]),
    .i_funct3   (r_funct3),
    .o_rdata    (w_ext),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_en       = 1'b0;
    mem_r_w      = 1'b0;
    mem_in       = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_fault != LSU_ERR_OK)                   w_state_next = S_RESP;
          else if (req_we && req_funct3 == FUNCT3_W)   w_state_next = S_WR;
          else                                         w_state_next = S_RD;
        end
      end
      S_RD: begin
        mem_en       = 1'b1;
        w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Read data is valid in the last wait cycle and captured on its edge.
        if (w_wait_done) w_state_next = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_en       = 1'b1;
        mem_r_w      = 1'b1;
        mem_in       = w_merged;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_err      <= LSU_ERR_OK;
      r_rdata    <= 32'h0;
      r_word     <= 32'h0;
      r_wait_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_fault;
        r_rdata  <= 32'h0;
      end
      if (r_state == S_RD) r_wait_cnt <= WAIT_INIT;
      if (r_state == S_RD_WAIT) begin
        if (!w_wait_done) r_wait_cnt <= r_wait_cnt - 1'b1;
        else if (r_we)    r_word     <= mem_out;
        else              r_rdata    <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// one-cycle-latency memory and a response scoreboard.
module tb_load_store_unit;
  import fullsend_pkg::*;

  localparam int unsigned MEM_WORDS  = 10240;
  localparam int unsigned MEM_RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_in;
  logic        mem_en;
  logic        mem_r_w;
  logic [31:0] mem_out;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nmis = 0;
  int          cyc = 0;
  int          first_rd;
  logic [31:0] first_addr;

  logic [31:0] ram [0:MEM_WORDS-1];
  logic        poke_en;
  logic [13:0] poke_idx;
  logic [31:0] poke_val;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .MEM_RD_LAT(MEM_RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_en      (mem_en),
    .mem_r_w     (mem_r_w),
    .mem_out     (mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (poke_en) ram[poke_idx] <= poke_val;
    else if (mem_en && mem_address < MEM_WORDS) begin
      if (mem_r_w) ram[mem_address[13:0]] <= mem_in;
      else         mem_out <= ram[mem_address[13:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 14'(idx);
    poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                        input int exp_lat, input int exp_rd, input int exp_wr, input int hold);
    exp_t e;
    exp_t g;
    int   t0;
    int   lat;
    int   rd;
    int   wr;
    bit   got;
    e = '{rdata: exp_rdata, err: exp_err, lat: exp_lat, rd: exp_rd, wr: exp_wr};
    @(negedge clk);
    chk({tag, "/req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    t0 = cyc; rd = 0; wr = 0; got = 1'b0; lat = 0;
    first_rd = -1; first_addr = 32'h0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (mem_r_w) wr++;
        else begin
          rd++;
          if (first_rd < 0) begin
            first_rd   = cyc - t0 + 1;
            first_addr = mem_address;
          end
        end
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = cyc - t0 + 1;
      end
    end
    chk({tag, "/resp_seen"}, {31'b0, got}, 32'd1);
    g = sb.pop_front();
    if (got) begin
      chk({tag, "/rdata"}, resp_rdata, g.rdata);
      chk({tag, "/err"}, {30'b0, resp_err}, {30'b0, g.err});
      chk({tag, "/latency"}, 32'(lat), 32'(g.lat));
      chk({tag, "/mem_reads"}, 32'(rd), 32'(g.rd));
      chk({tag, "/mem_writes"}, 32'(wr), 32'(g.wr));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "/hold_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "/hold_rdata"}, resp_rdata, g.rdata);
        chk({tag, "/hold_req_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, "/hold_mem_en"}, {31'b0, mem_en}, 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "/ready_after"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "/valid_after"}, {31'b0, resp_valid}, 32'd0);
    end
  endtask

  initial begin
    int abort_wr;
    int abort_resp;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    poke_en    = 1'b0;
    poke_idx   = 14'h0;
    poke_val   = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst/req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst/resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst/resp_rdata", resp_rdata, 32'h0);
    chk("rst/resp_err", {30'b0, resp_err}, 32'h0);
    chk("rst/mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst/mem_r_w", {31'b0, mem_r_w}, 32'd0);
    chk("rst/mem_in", mem_in, 32'h0);
    chk("rst/mem_address", mem_address, 32'h0);
    reset = 1'b1;

    // Loads
    poke(4, 32'hDEADBEEF);
    do_req("lw", 1'b0, FUNCT3_W, 32'h10, 32'h0, 32'hDEADBEEF, LSU_ERR_OK, 3, 1, 0, 0);
    chk("lw/rd_cycle", 32'(first_rd), 32'd1);
    chk("lw/rd_addr", first_addr, 32'd4);
    poke(4, 32'h80FF0011);
    do_req("lb", 1'b0, FUNCT3_B, 32'h13, 32'h0, 32'hFFFFFF80, LSU_ERR_OK, 3, 1, 0, 0);
    do_req("lbu", 1'b0, FUNCT3_BU, 32'h13, 32'h0, 32'h00000080, LSU_ERR_OK, 3, 1, 0, 0);
    do_req("lhu", 1'b0, FUNCT3_HU, 32'h12, 32'h0, 32'h000080FF, LSU_ERR_OK, 3, 1, 0, 0);
    do_req("lh", 1'b0, FUNCT3_H, 32'h12, 32'h0, 32'hFFFF80FF, LSU_ERR_OK, 3, 1, 0, 0);
    do_req("lb0", 1'b0, FUNCT3_B, 32'h10, 32'h0, 32'h00000011, LSU_ERR_OK, 3, 1, 0, 0);
    do_req("lh0", 1'b0, FUNCT3_H, 32'h10, 32'h0, 32'h00000011, LSU_ERR_OK, 3, 1, 0, 0);

    // Stores
    poke(4, 32'h11223344);
    do_req("sb", 1'b1, FUNCT3_B, 32'h11, 32'hFFFFFFAA, 32'h0, LSU_ERR_OK, 4, 1, 1, 0);
    chk("sb/ram", ram[4], 32'h1122AA44);
    poke(8, 32'h0);
    do_req("sw", 1'b1, FUNCT3_W, 32'h20, 32'h12345678, 32'h0, LSU_ERR_OK, 2, 0, 1, 0);
    chk("sw/ram", ram[8], 32'h12345678);
    do_req("sh", 1'b1, FUNCT3_H, 32'h22, 32'h0000BEEF, 32'h0, LSU_ERR_OK, 4, 1, 1, 0);
    chk("sh/ram", ram[8], 32'hBEEF5678);

    // Faults and boundaries
    do_req("lh_mis", 1'b0, FUNCT3_H, 32'h11, 32'h0, 32'h0, LSU_ERR_MISALIGN, 1, 0, 0, 0);
    do_req("lw_oor", 1'b0, FUNCT3_W, 32'(4 * MEM_WORDS), 32'h0, 32'h0, LSU_ERR_RANGE, 1, 0, 0, 0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, LSU_ERR_ILLEGAL, 1, 0, 0, 0);
    do_req("sbu_ill", 1'b1, FUNCT3_BU, 32'h10, 32'h55, 32'h0, LSU_ERR_ILLEGAL, 1, 0, 0, 0);
    do_req("prio_ill", 1'b0, 3'b111, 32'(4 * MEM_WORDS + 1), 32'h0, 32'h0, LSU_ERR_ILLEGAL, 1, 0, 0, 0);
    do_req("prio_mis", 1'b0, FUNCT3_W, 32'(4 * MEM_WORDS + 2), 32'h0, 32'h0, LSU_ERR_MISALIGN, 1, 0, 0, 0);
    do_req("sw_oor", 1'b1, FUNCT3_W, 32'(4 * MEM_WORDS), 32'h1, 32'h0, LSU_ERR_RANGE, 1, 0, 0, 0);
    poke(MEM_WORDS - 1, 32'h5A5A0F0F);
    do_req("lw_last", 1'b0, FUNCT3_W, 32'(4 * (MEM_WORDS - 1)), 32'h0, 32'h5A5A0F0F, LSU_ERR_OK, 3, 1, 0, 0);

    // Backpressure: response held five cycles
    do_req("lw_hold", 1'b0, FUNCT3_W, 32'h20, 32'h0, 32'hBEEF5678, LSU_ERR_OK, 3, 1, 0, 5);

    // Reset during the read wait of a halfword store
    poke(12, 32'hCAFEBABE);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = FUNCT3_H;
    req_addr   = 32'h30;
    req_wdata  = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort/rd_en", {31'b0, mem_en}, 32'd1);
    chk("abort/rd_rw", {31'b0, mem_r_w}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort/req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort/resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort/mem_en", {31'b0, mem_en}, 32'd0);
    chk("abort/mem_r_w", {31'b0, mem_r_w}, 32'd0);
    chk("abort/mem_in", mem_in, 32'h0);
    chk("abort/mem_address", mem_address, 32'h0);
    chk("abort/resp_rdata", resp_rdata, 32'h0);
    abort_wr = 0;
    abort_resp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      if (mem_en) abort_wr++;
      if (resp_valid) abort_resp++;
    end
    chk("abort/no_mem_en", 32'(abort_wr), 32'd0);
    chk("abort/no_resp", 32'(abort_resp), 32'd0);
    chk("abort/ram", ram[12], 32'hCAFEBABE);
    do_req("lw_after", 1'b0, FUNCT3_W, 32'h30, 32'h0, 32'hCAFEBABE, LSU_ERR_OK, 3, 1, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
